// File: rtl/framed_shiftregister.sv
// Parametrised shift register with frame tracking: loads a word, shifts WIDTH bits
// on peripheral strobes, then pulses frameDone and captures the received word.
module framed_shiftregister #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             peripheralClkEdge,
    input  logic             parallelLoad,
    input  logic [WIDTH-1:0] parallelDataIn,
    input  logic             serialDataIn,
    output logic [WIDTH-1:0] parallelDataOut,
    output logic             serialDataOut,
    output logic             busy,
    output logic             frameDone,
    output logic [WIDTH-1:0] rxWord
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state, stateNext;
    logic [WIDTH-1:0] shiftReg, shiftRegNext, shifted;
    logic [CW-1:0]    bitCount, bitCountNext;
    logic [WIDTH-1:0] rxWordNext;
    logic             frameDoneNext;

    always_comb begin
        if (LSB_FIRST) shifted = {serialDataIn, shiftReg[WIDTH-1:1]};
        else           shifted = {shiftReg[WIDTH-2:0], serialDataIn};
    end

    // Load always wins over a coincident strobe, in either state.
    always_comb begin
        stateNext     = state;
        shiftRegNext  = shiftReg;
        bitCountNext  = bitCount;
        rxWordNext    = rxWord;
        frameDoneNext = 1'b0;
        if (parallelLoad) begin
            shiftRegNext = parallelDataIn;
            bitCountNext = '0;
            stateNext    = SHIFT;
        end else if (peripheralClkEdge) begin
            shiftRegNext = shifted;
            if (state == SHIFT) begin
                if (bitCount == CW'(WIDTH - 1)) begin
                    rxWordNext    = shifted;
                    frameDoneNext = 1'b1;
                    bitCountNext  = '0;
                    stateNext     = IDLE;
                end else begin
                    bitCountNext = bitCount + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            shiftReg  <= '0;
            bitCount  <= '0;
            rxWord    <= '0;
            frameDone <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= stateNext;
            shiftReg  <= shiftRegNext;
            bitCount  <= bitCountNext;
            rxWord    <= rxWordNext;
            frameDone <= frameDoneNext;
            busy      <= (stateNext == SHIFT);
        end
    end

    assign parallelDataOut = shiftReg;
    assign serialDataOut   = LSB_FIRST ? shiftReg[0] : shiftReg[WIDTH-1];

endmodule

// File: tb/tb_framed_shiftregister.sv
// Scoreboard bench: MSB-first and LSB-first instances; expected rxWord values are
// queued at frame start and popped by a monitor on each frameDone pulse.
module tb_framed_shiftregister;

    logic       clk = 1'b0;
    logic       resetN;

    logic       aStrobe, aLoad, aSin, aSout, aBusy, aDone;
    logic [7:0] aData, aPout, aRx;
    logic       bStrobe, bLoad, bSin, bSout, bBusy, bDone;
    logic [7:0] bData, bPout, bRx;

    int checks = 0;
    int errors = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    always #5 clk = ~clk;

    framed_shiftregister #(.WIDTH(8), .LSB_FIRST(1'b0)) dutA (
        .clk(clk), .resetN(resetN), .peripheralClkEdge(aStrobe), .parallelLoad(aLoad),
        .parallelDataIn(aData), .serialDataIn(aSin), .parallelDataOut(aPout),
        .serialDataOut(aSout), .busy(aBusy), .frameDone(aDone), .rxWord(aRx)
    );

    framed_shiftregister #(.WIDTH(8), .LSB_FIRST(1'b1)) dutB (
        .clk(clk), .resetN(resetN), .peripheralClkEdge(bStrobe), .parallelLoad(bLoad),
        .parallelDataIn(bData), .serialDataIn(bSin), .parallelDataOut(bPout),
        .serialDataOut(bSout), .busy(bBusy), .frameDone(bDone), .rxWord(bRx)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every frameDone must match the next queued expected word.
    always @(negedge clk) begin
        if (aDone) begin
            if (qa.size() == 0) check("a_unexpected_frameDone", 1, 0);
            else check("a_rxWord", {24'd0, aRx}, {24'd0, qa.pop_front()});
        end
        if (bDone) begin
            if (qb.size() == 0) check("b_unexpected_frameDone", 1, 0);
            else check("b_rxWord", {24'd0, bRx}, {24'd0, qb.pop_front()});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "timeout");
    end

    task automatic checkAZero(input string tag);
        check({tag, "_pout"}, {24'd0, aPout}, 0);
        check({tag, "_sout"}, {31'd0, aSout}, 0);
        check({tag, "_busy"}, {31'd0, aBusy}, 0);
        check({tag, "_done"}, {31'd0, aDone}, 0);
        check({tag, "_rx"},   {24'd0, aRx},   0);
    endtask

    task automatic aStrobes(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            aStrobe = 1'b1;
            tick();
        end
        aStrobe = 1'b0;
    endtask

    initial begin
        logic [7:0] exp;
        resetN = 1'b0;
        {aStrobe, aLoad, aSin} = '0; aData = '0;
        {bStrobe, bLoad, bSin} = '0; bData = '0;
        tick();
        tick();
        checkAZero("reset_initial");
        resetN = 1'b1;
        tick();

        // MSB-first loopback frame of A5
        aData = 8'hA5; aLoad = 1'b1; qa.push_back(8'hA5);
        tick();
        aLoad = 1'b0;
        check("t2_busy_after_load", {31'd0, aBusy}, 1);
        check("t2_pout_after_load", {24'd0, aPout}, 32'hA5);
        exp = 8'hA5;
        for (int unsigned i = 0; i < 8; i++) begin
            check($sformatf("t2_sout_bit%0d", i), {31'd0, aSout}, {31'd0, exp[7-i]});
            aSin = aSout; aStrobe = 1'b1;
            tick();
        end
        aStrobe = 1'b0;
        check("t2_done_pulse", {31'd0, aDone}, 1);
        check("t2_busy_end", {31'd0, aBusy}, 0);
        check("t2_pout_end", {24'd0, aPout}, 32'hA5);
        tick();
        check("t2_done_low", {31'd0, aDone}, 0);

        // Asynchronous reset mid-period with register and rxWord non-zero
        aData = 8'h3C; aLoad = 1'b1;
        tick();
        aLoad = 1'b0;
        #2 resetN = 1'b0;
        #1 checkAZero("t1_async");
        #2 resetN = 1'b1;
        tick();
        check("t1_busy_idle", {31'd0, aBusy}, 0);

        // LSB-first frame of 1F shifting in zeros
        bData = 8'h1F; bLoad = 1'b1; qb.push_back(8'h00);
        tick();
        bLoad = 1'b0; bSin = 1'b0;
        exp = 8'h1F;
        for (int unsigned i = 0; i < 8; i++) begin
            check($sformatf("t3_sout_bit%0d", i), {31'd0, bSout}, {31'd0, exp[i]});
            bStrobe = 1'b1;
            tick();
        end
        bStrobe = 1'b0;
        check("t3_pout", {24'd0, bPout}, 0);
        check("t3_busy", {31'd0, bBusy}, 0);
        check("t3_rx", {24'd0, bRx}, 0);

        // Abort by reload coincident with a strobe
        aData = 8'hF0; aLoad = 1'b1;
        tick();
        aLoad = 1'b0; aSin = 1'b0;
        aStrobes(3);
        check("t4_pout_3shift", {24'd0, aPout}, 32'h80);
        aData = 8'h0F; aLoad = 1'b1; aStrobe = 1'b1; qa.push_back(8'hFF);
        tick();
        aLoad = 1'b0; aStrobe = 1'b0;
        check("t4_pout_reload", {24'd0, aPout}, 32'h0F);
        check("t4_done_reload", {31'd0, aDone}, 0);
        check("t4_busy_reload", {31'd0, aBusy}, 1);
        aSin = 1'b1;
        aStrobes(7);
        check("t4_done_after7", {31'd0, aDone}, 0);
        check("t4_busy_after7", {31'd0, aBusy}, 1);
        check("t4_pout_after7", {24'd0, aPout}, 32'hFF);
        aStrobes(1);
        check("t4_done_after8", {31'd0, aDone}, 1);
        check("t4_busy_after8", {31'd0, aBusy}, 0);

        // Reset mid-frame; subsequent strobes are free-run only
        aData = 8'hC3; aLoad = 1'b1;
        tick();
        aLoad = 1'b0; aSin = 1'b0;
        aStrobes(4);
        check("t5_pout_4shift", {24'd0, aPout}, 32'h30);
        #2 resetN = 1'b0;
        #1 checkAZero("t5_async");
        #2 resetN = 1'b1;
        aSin = 1'b1;
        aStrobes(4);
        check("t5_rx", {24'd0, aRx}, 0);
        check("t5_busy", {31'd0, aBusy}, 0);
        check("t5_pout", {24'd0, aPout}, 32'h0F);

        // Idle free-run from a clean reset
        #2 resetN = 1'b0;
        #2 resetN = 1'b1;
        aSin = 1'b1;
        aStrobes(3);
        check("t6_pout", {24'd0, aPout}, 32'h07);
        check("t6_busy", {31'd0, aBusy}, 0);
        tick();
        tick();

        check("qa_drained", qa.size(), 0);
        check("qb_drained", qb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/framed_shiftregister.md
Name: framed_shiftregister

Overview:
Parametrised successor to the basic 8-bit shift register. It loads a WIDTH-bit word, then on each peripheralClkEdge shifts one bit out while shifting one bit in, in a selectable bit order. A bit counter and a small FSM track frame progress: after exactly WIDTH shifts the block flags frame completion and captures the received word. It sits between the SPI-style peripheral edge detector and the register file / memory interface.

Parameters:
WIDTH, 8, shift register and word width; legal range WIDTH >= 2.
LSB_FIRST, 0, bit order. 0 = MSB shifted out first, serial bit enters at bit 0. 1 = LSB shifted out first, serial bit enters at bit WIDTH-1.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
resetN  input  1  asynchronous, active-low reset.
peripheralClkEdge  input  1  shift strobe, sampled on clk. Shifts once per clk cycle in which it is high.
parallelLoad  input  1  load parallelDataIn and start a frame.
parallelDataIn  input  WIDTH  word to transmit.
serialDataIn  input  1  incoming serial bit.
parallelDataOut  output  WIDTH  live shift register contents.
serialDataOut  output  1  current outgoing bit: reg[WIDTH-1] if LSB_FIRST=0, reg[0] if LSB_FIRST=1.
busy  output  1  high while state is SHIFT.
frameDone  output  1  one-cycle pulse at end of frame.
rxWord  output  WIDTH  word captured at end of last completed frame.

Behaviour:
- Reset (resetN low, any time, independent of clk):
  - register, bit counter, rxWord = 0; frameDone, busy = 0; state = IDLE.
  - serialDataOut = 0.
  - Takes effect immediately, including mid-frame. An aborted frame never produces frameDone.
- Shift operation:
  - LSB_FIRST=0: reg <= {reg[WIDTH-2:0], serialDataIn}.
  - LSB_FIRST=1: reg <= {serialDataIn, reg[WIDTH-1:1]}.
- Priority each clk edge: parallelLoad > peripheralClkEdge > hold.
- State IDLE:
  - parallelLoad: reg <= parallelDataIn, count <= 0, go to SHIFT.
  - peripheralClkEdge only: free-run shift, legacy behaviour. No counting, stay in IDLE, no frameDone.
- State SHIFT:
  - parallelLoad: abort current frame. Reload reg, count <= 0, stay in SHIFT, no frameDone.
  - peripheralClkEdge with count < WIDTH-1: shift, count++.
  - peripheralClkEdge with count == WIDTH-1 (the WIDTH-th shift):
    - shift;
    - rxWord <= post-shift register value;
    - frameDone <= 1;
    - count <= 0;
    - go to IDLE.
  - Neither input: hold all state.
- Output timing:
  - frameDone is registered: high for exactly one clk cycle following the final-shift edge, low otherwise.
  - rxWord updates on the same edge that sets frameDone and holds until the next completed frame.
  - busy is registered and equals (state == SHIFT). It goes high the cycle after the load edge and low the cycle after the final-shift edge.
- Bit counter: width $clog2(WIDTH); counter overflow is impossible.
- Latency: load to first serialDataOut bit = 1 clk. Frame = load + WIDTH strobes. Strobes may be back-to-back; no idle cycles required.
- peripheralClkEdge held high for N cycles gives N shifts.
- parallelLoad held high for multiple cycles reloads every cycle; no shifting occurs while it is high.

Test Plan:
1. Reset: resetN low mid-clock-period with reg non-zero -> all outputs 0 before the next clk edge. Release: state IDLE, busy 0.
2. WIDTH=8, LSB_FIRST=0, load 8'hA5, serialDataIn looped from serialDataOut, 8 consecutive strobes -> serialDataOut sequence 1,0,1,0,0,1,0,1; frameDone high exactly one cycle after 8th strobe; rxWord=8'hA5; busy 0.
3. LSB_FIRST=1, load 8'h1F, serialDataIn=0, 8 strobes -> serialDataOut sequence 1,1,1,1,1,0,0,0; rxWord=8'h00; parallelDataOut=8'h00.
4. Abort/priority: load 8'hF0, 3 strobes, then parallelLoad=1 with 8'h0F in the same cycle as a strobe -> parallelDataOut=8'h0F (no shift), no frameDone; frameDone only after 8 further strobes.
5. Reset mid-frame: load 8'hC3, 4 strobes, pulse resetN low -> outputs 0 immediately; after release plus 4 more strobes, frameDone stays 0 and rxWord stays 8'h00.
6. Idle free-run: no load, serialDataIn=1, 3 strobes -> parallelDataOut=8'h07 (LSB_FIRST=0), busy 0, frameDone never asserted.
